// File: rtl/rs_decode_ctrl_if.sv
// Handshake and control bundle between the RS decode controller and its datapath/environment.
// The slave side is the controller; the master side drives requests and datapath status.
interface rs_decode_ctrl_if;
  logic       START;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] WR_ADDR;
  logic       SYN_CLR;
  logic       SYN_EN;
  logic       SYN_ZERO;
  logic       KES_START;
  logic       KES_DONE;
  logic       KES_FAIL;
  logic       CHIEN_EN;
  logic [3:0] CHIEN_IDX;
  logic [3:0] RD_ADDR;
  logic       CORR_EN;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       BUSY;
  logic       DONE;
  logic       FAIL;

  modport slave (
    input  START, IN_VALID, SYN_ZERO, KES_DONE, KES_FAIL, OUT_READY,
    output IN_READY, WR_ADDR, SYN_CLR, SYN_EN, KES_START, CHIEN_EN, CHIEN_IDX,
           RD_ADDR, CORR_EN, OUT_VALID, BUSY, DONE, FAIL
  );

  modport master (
    output START, IN_VALID, SYN_ZERO, KES_DONE, KES_FAIL, OUT_READY,
    input  IN_READY, WR_ADDR, SYN_CLR, SYN_EN, KES_START, CHIEN_EN, CHIEN_IDX,
           RD_ADDR, CORR_EN, OUT_VALID, BUSY, DONE, FAIL
  );
endinterface

// File: rtl/rs_decode_ctrl.sv
// Sequencing controller for a Reed-Solomon decoder: load, syndrome check, key-equation
// solve with timeout, Chien search, and corrected output of the data symbols.
//
// state   | meaning
// IDLE    | waiting for START
// LOAD    | accepting N symbols into the buffer, syndromes accumulating
// EVAL    | one cycle: decide error-free vs. launch key-equation solver
// KES     | waiting for solver done, bounded by KES_TIMEOUT
// CHIEN   | sweeping all N symbol positions
// OUT     | presenting K data symbols downstream
// FIN     | one-cycle DONE pulse
module rs_decode_ctrl #(
  parameter int N           = 15,
  parameter int K           = 11,
  parameter int KES_TIMEOUT = 31
) (
  input  logic          CLK,
  input  logic          RESET,
  rs_decode_ctrl_if.slave bus
);
  localparam int             TW       = $clog2(KES_TIMEOUT + 1);
  localparam logic [3:0]     LAST_IN  = 4'(N - 1);
  localparam logic [3:0]     LAST_OUT = 4'(K - 1);
  // Timer is loaded in EVAL and expires on its last KES cycle, so OUT begins
  // exactly KES_TIMEOUT cycles after the KES_START pulse.
  localparam logic [TW-1:0]  TMR_LOAD = TW'(KES_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EVAL, S_KES, S_CHIEN, S_OUT, S_FIN
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic          r_corr, w_corr_nxt;
  logic          r_fail, w_fail_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_corr  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmr   <= w_tmr_nxt;
      r_corr  <= w_corr_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tmr_nxt     = r_tmr;
    w_corr_nxt    = r_corr;
    w_fail_nxt    = r_fail;
    bus.IN_READY  = 1'b0;
    bus.WR_ADDR   = 4'd0;
    bus.SYN_CLR   = 1'b0;
    bus.SYN_EN    = 1'b0;
    bus.KES_START = 1'b0;
    bus.CHIEN_EN  = 1'b0;
    bus.CHIEN_IDX = 4'd0;
    bus.RD_ADDR   = 4'd0;
    bus.CORR_EN   = 1'b0;
    bus.OUT_VALID = 1'b0;
    bus.DONE      = 1'b0;
    bus.BUSY      = (r_state != S_IDLE);
    bus.FAIL      = r_fail;

    case (r_state)
      S_IDLE: begin
        if (bus.START) begin
          bus.SYN_CLR = 1'b1;
          w_fail_nxt  = 1'b0;
          w_corr_nxt  = 1'b0;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.IN_READY = 1'b1;
        bus.WR_ADDR  = r_cnt;
        if (bus.IN_VALID) begin
          bus.SYN_EN = 1'b1;
          if (r_cnt == LAST_IN) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_EVAL;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      S_EVAL: begin
        if (bus.SYN_ZERO) begin
          w_corr_nxt  = 1'b0;
          w_state_nxt = S_OUT;
        end else begin
          bus.KES_START = 1'b1;
          w_tmr_nxt     = TMR_LOAD;
          w_state_nxt   = S_KES;
        end
      end
      S_KES: begin
        if (bus.KES_DONE) begin
          if (bus.KES_FAIL) begin
            w_fail_nxt  = 1'b1;
            w_corr_nxt  = 1'b0;
            w_state_nxt = S_OUT;
          end else begin
            w_state_nxt = S_CHIEN;
          end
        end else if (r_tmr == '0) begin
          w_fail_nxt  = 1'b1;
          w_corr_nxt  = 1'b0;
          w_state_nxt = S_OUT;
        end else begin
          w_tmr_nxt = r_tmr - TW'(1);
        end
      end
      S_CHIEN: begin
        bus.CHIEN_EN  = 1'b1;
        bus.CHIEN_IDX = r_cnt;
        if (r_cnt == LAST_IN) begin
          w_cnt_nxt   = 4'd0;
          w_corr_nxt  = 1'b1;
          w_state_nxt = S_OUT;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_OUT: begin
        bus.OUT_VALID = 1'b1;
        bus.RD_ADDR   = r_cnt;
        bus.CORR_EN   = r_corr;
        if (bus.OUT_READY) begin
          if (r_cnt == LAST_OUT) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_FIN;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      S_FIN: begin
        bus.DONE    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Reset wins over any same-cycle request: nothing leaves the block while it is held.
    if (RESET) begin
      bus.IN_READY  = 1'b0;
      bus.WR_ADDR   = 4'd0;
      bus.SYN_CLR   = 1'b0;
      bus.SYN_EN    = 1'b0;
      bus.KES_START = 1'b0;
      bus.CHIEN_EN  = 1'b0;
      bus.CHIEN_IDX = 4'd0;
      bus.RD_ADDR   = 4'd0;
      bus.CORR_EN   = 1'b0;
      bus.OUT_VALID = 1'b0;
      bus.DONE      = 1'b0;
      bus.BUSY      = 1'b0;
      bus.FAIL      = 1'b0;
    end
  end
endmodule

// File: tb/tb_rs_decode_ctrl.sv
// Bench for rs_decode_ctrl: directed codeword scenarios, a count-based model checked every
// cycle, and literal timing/count expectations per scenario.
module tb_rs_decode_ctrl;
  localparam int N = 15;
  localparam int K = 11;

  logic CLK;
  logic RESET;
  rs_decode_ctrl_if b();

  rs_decode_ctrl #(.N(N), .K(K), .KES_TIMEOUT(31)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b)
  );

  logic [21:0] all_outs;
  assign all_outs = {b.IN_READY, b.WR_ADDR, b.SYN_CLR, b.SYN_EN, b.KES_START, b.CHIEN_EN,
                     b.CHIEN_IDX, b.RD_ADDR, b.CORR_EN, b.OUT_VALID, b.BUSY, b.DONE, b.FAIL};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // model state, written only by the compare process
  int m_acc = N, m_out = 0, m_chien = 0;
  int n_writes = 0, n_kes = 0, n_corr = 0, n_stall4 = 0, n_done = 0;
  int t_last_in = -1, t_kes = -1, t_out0 = -1;
  // per-codeword expectations, written only by the stimulus process
  bit m_corr_exp = 0, m_fail_exp = 0;
  int g_t_start = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Compare process: every cycle, outputs must agree with what the symbol/output counts imply.
  initial forever begin
    @(negedge CLK);
    if (RESET) begin
      chk("outs_in_reset", int'(all_outs), 0);
      m_acc   = N;
      m_out   = 0;
      m_chien = 0;
    end else begin
      chk("syn_en", int'(b.SYN_EN), int'(b.IN_READY & b.IN_VALID));
      if (b.IN_READY) begin
        chk("wr_addr", int'(b.WR_ADDR), m_acc);
        chk("fail_clear_on_load", int'(b.FAIL), 0);
      end
      if (m_acc == N) chk("no_extra_in", int'(b.IN_READY), 0);
      if (b.SYN_CLR) chk("start_only_idle", int'(b.BUSY), 0);
      if (b.KES_START) chk("kes_after_load", m_acc, N);
      if (b.CHIEN_EN) begin
        chk("chien_idx", int'(b.CHIEN_IDX), m_chien);
        chk("chien_after_load", m_acc, N);
      end
      if (b.OUT_VALID) begin
        chk("rd_addr", int'(b.RD_ADDR), m_out);
        chk("corr_en", int'(b.CORR_EN), int'(m_corr_exp));
        chk("fail_in_out", int'(b.FAIL), int'(m_fail_exp));
        chk("chien_count_before_out", m_chien, m_corr_exp ? N : 0);
      end
      if (b.DONE) chk("done_after_k", m_out, K);
      if (!b.BUSY && m_out == K) chk("fail_held", int'(b.FAIL), int'(m_fail_exp));

      if (b.SYN_CLR) begin
        m_acc = 0; m_out = 0; m_chien = 0;
        n_writes = 0; n_kes = 0; n_corr = 0; n_stall4 = 0; n_done = 0;
        t_last_in = -1; t_kes = -1; t_out0 = -1;
      end
      if (b.IN_READY && b.IN_VALID) begin
        m_acc++;
        n_writes++;
        if (m_acc == N) t_last_in = cyc;
      end
      if (b.KES_START) begin
        n_kes++;
        t_kes = cyc;
      end
      if (b.CHIEN_EN) m_chien++;
      if (b.OUT_VALID) begin
        if (t_out0 < 0) t_out0 = cyc;
        if (!b.OUT_READY && b.RD_ADDR == 4'd4) n_stall4++;
        if (b.OUT_READY) begin
          m_out++;
          if (b.CORR_EN) n_corr++;
        end
      end
      if (b.DONE) n_done++;
    end
  end

  // kes_dly: cycles after KES_START that KES_DONE is driven (large = never)
  task automatic run_cw(input bit zero, input int kes_dly, input bit kfail, input bit alt,
                        input int stall_len, input bit rst_mid, input bit exp_corr,
                        input bit exp_fail);
    int kes_cnt = -1;
    int n_ok    = 0;
    int stalled = 0;
    bit fin     = 0;
    bit do_rst  = 0;
    @(posedge CLK); #1;
    b.START = 1'b1; b.SYN_ZERO = zero; b.IN_VALID = 1'b0;
    b.KES_DONE = 1'b0; b.KES_FAIL = 1'b0; b.OUT_READY = 1'b1;
    @(negedge CLK);
    g_t_start = cyc;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(posedge CLK); #1;
      if (c == 0) begin
        m_corr_exp = exp_corr;
        m_fail_exp = exp_fail;
      end
      b.START    = 1'b0;
      b.IN_VALID = alt ? ((c % 2) == 0) : 1'b1;
      if (kes_cnt >= 0) kes_cnt++;
      b.KES_DONE  = (kes_cnt == kes_dly);
      b.KES_FAIL  = b.KES_DONE & kfail;
      b.OUT_READY = !(n_ok == 4 && stalled < stall_len);
      if (do_rst) RESET = 1'b1;
      @(negedge CLK);
      if (do_rst) fin = 1'b1;
      if (b.KES_DONE) kes_cnt = -1;
      if (b.KES_START) kes_cnt = 0;
      if (b.OUT_VALID) begin
        if (b.OUT_READY) n_ok++;
        else stalled++;
      end
      if (b.DONE) fin = 1'b1;
      if (rst_mid && b.CHIEN_EN && b.CHIEN_IDX == 4'd6) do_rst = 1'b1;
    end
    chk("codeword_completes", int'(fin), 1);
    @(posedge CLK); #1;
    RESET = 1'b0; b.IN_VALID = 1'b0; b.OUT_READY = 1'b0; b.KES_DONE = 1'b0; b.KES_FAIL = 1'b0;
    @(negedge CLK);
    if (do_rst) begin
      chk("midrst_outs", int'(all_outs), 0);
      chk("midrst_busy", int'(b.BUSY), 0);
    end
  endtask

  initial begin
    RESET = 1'b1;
    b.START = 1'b0; b.IN_VALID = 1'b0; b.SYN_ZERO = 1'b0;
    b.KES_DONE = 1'b0; b.KES_FAIL = 1'b0; b.OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1 b.START = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; b.START = 1'b0;
    @(negedge CLK);
    chk("reset_outs", int'(all_outs), 0);
    @(posedge CLK);
    @(negedge CLK);
    chk("start_in_reset_ignored", int'(b.BUSY), 0);

    // error-free, back-to-back input
    run_cw(1'b1, 1000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("ef_no_kes", n_kes, 0);
    chk("ef_load_span", t_last_in - g_t_start, 15);
    chk("ef_latency", t_out0 - t_last_in, 2);
    chk("ef_writes", n_writes, 15);
    chk("ef_outputs", m_out, 11);
    chk("ef_corr", n_corr, 0);
    chk("ef_done", n_done, 1);
    chk("ef_fail", int'(b.FAIL), 0);

    // correctable: solver done 5 cycles after launch
    run_cw(1'b0, 5, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("cor_kes", n_kes, 1);
    chk("cor_chien", m_chien, 15);
    chk("cor_out_time", t_out0 - t_kes, 21);
    chk("cor_corr", n_corr, 11);
    chk("cor_fail", int'(b.FAIL), 0);

    // uncorrectable
    run_cw(1'b0, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("unc_chien", m_chien, 0);
    chk("unc_out_time", t_out0 - t_kes, 4);
    chk("unc_outputs", m_out, 11);
    chk("unc_corr", n_corr, 0);
    chk("unc_fail", int'(b.FAIL), 1);
    repeat (3) @(negedge CLK);
    chk("unc_fail_held", int'(b.FAIL), 1);

    // solver timeout
    run_cw(1'b0, 1000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("to_out_time", t_out0 - t_kes, 31);
    chk("to_chien", m_chien, 0);
    chk("to_fail", int'(b.FAIL), 1);

    // input gaps and output backpressure at index 4
    run_cw(1'b1, 1000, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    chk("bp_writes", n_writes, 15);
    chk("bp_load_span", t_last_in - g_t_start, 29);
    chk("bp_stall4", n_stall4, 3);
    chk("bp_outputs", m_out, 11);
    chk("bp_latency", t_out0 - t_last_in, 2);
    chk("bp_fail_cleared", int'(b.FAIL), 0);

    // reset in the middle of the Chien sweep, then a normal codeword
    run_cw(1'b0, 2, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("mr_no_done", n_done, 0);
    run_cw(1'b1, 1000, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("mr_after_done", n_done, 1);
    chk("mr_after_outputs", m_out, 11);
    chk("mr_after_latency", t_out0 - t_last_in, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
